mips_cpu_lsu: RTL and testbench

Parametrised load/store unit for the multicycle MIPS CPU: accepts one memory operation at a time from the execute stage and drives the Avalon memory-mapped master port. It performs:
- effective-address generation, byte-lane steering, sign/zero extension and LWL/LWR merging;
- waitrequest handling, with a bounded-wait timeout.

It replaces the ad-hoc address/readdata handling inside the CPU's EXEC/MEM_ACCESS states.

---
 rtl/mips_cpu_lsu_if.sv | 32 +++
 rtl/mips_cpu_lsu.sv | 187 ++++++++++++++++++
 tb/tb_mips_cpu_lsu.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_lsu_if.sv
// Execute-stage request/response and Avalon-MM master signals of the MIPS load/store unit.
// The master modport is the LSU side; the slave modport is the execute stage plus the memory.
interface mips_cpu_lsu_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [3:0]            req_op;
  logic [31:0]           req_base;
  logic [15:0]           req_offset;
  logic [31:0]           req_rt_data;
  logic                  resp_valid;
  logic [31:0]           resp_data;
  logic                  resp_err;
  logic [ADDR_WIDTH-1:0] address;
  logic                  read;
  logic                  write;
  logic                  waitrequest;
  logic [31:0]           writedata;
  logic [3:0]            byteenable;
  logic [31:0]           readdata;

  modport master (
    input  req_valid, req_op, req_base, req_offset, req_rt_data, waitrequest, readdata,
    output req_ready, resp_valid, resp_data, resp_err, address, read, write, writedata, byteenable
  );

  modport slave (
    output req_valid, req_op, req_base, req_offset, req_rt_data, waitrequest, readdata,
    input  req_ready, resp_valid, resp_data, resp_err, address, read, write, writedata, byteenable
  );
endinterface

// File: rtl/mips_cpu_lsu.sv
// MIPS load/store unit: one access at a time, strobe in cycle 1, response in cycle 2+N (N = waitrequest-high cycles), bounded by TIMEOUT_CYCLES.
// Backpressure: req_ready only in IDLE; waitrequest stalls BUS. Optional MIPS_LSU_ALIGN_CHECK_EN rejects misaligned LH/LHU/SH/LW/SW.
module mips_cpu_lsu #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  mips_cpu_lsu_if.master   bus
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [3:0] OP_LB = 4'd0, OP_LBU = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3,
                         OP_LW = 4'd4, OP_LWL = 4'd5, OP_LWR = 4'd6,
                         OP_SB = 4'd8, OP_SH = 4'd9, OP_SW = 4'd10;

  localparam int          CW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit          TO_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] T_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef struct packed {
    logic [3:0]  op;
    logic [1:0]  b;
    logic [31:0] rt;
  } req_t;

  state_t                state, state_d;
  req_t                  req_q;
  logic [CW-1:0]         wait_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q, rdata_q;
  logic [3:0]            be_q;
  logic                  read_q, write_q, rvld_q, rerr_q;

  logic [31:0] eff, wd_in, load_fmt;
  logic [1:0]  b_in;
  logic [3:0]  be_in;
  logic        illegal, misaligned, reject, accept, bus_done, timeout;

  assign eff  = bus.req_base + {{16{bus.req_offset[15]}}, bus.req_offset};
  assign b_in = eff[1:0];

  always_comb begin
    wd_in   = 32'h0;
    be_in   = 4'b1111;
    illegal = 1'b0;
    case (bus.req_op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR: be_in = 4'b1111;
      OP_SB: begin
        wd_in = {4{bus.req_rt_data[7:0]}};
        be_in = 4'b0001 << b_in;
      end
      OP_SH: begin
        wd_in = {2{bus.req_rt_data[15:0]}};
        be_in = b_in[1] ? 4'b1100 : 4'b0011;
      end
      OP_SW: wd_in = bus.req_rt_data;
      default: begin
        illegal = 1'b1;
        be_in   = 4'b0000;
      end
    endcase
  end

`ifdef MIPS_LSU_ALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    case (bus.req_op)
      OP_LH, OP_LHU, OP_SH: misaligned = b_in[0];
      OP_LW, OP_SW:         misaligned = (b_in != 2'b00);
      default:              misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  assign reject = illegal | misaligned;

  // Result shaping uses the byte offset captured at acceptance; 3-b equals ~b for a 2-bit b.
  logic [4:0]  lsh, rsh;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] rd_shr;
  assign lsh      = {~req_q.b, 3'b000};
  assign rsh      = {req_q.b, 3'b000};
  assign rd_shr   = bus.readdata >> rsh;
  assign byte_sel = rd_shr[7:0];
  assign half_sel = req_q.b[1] ? bus.readdata[31:16] : bus.readdata[15:0];

  always_comb begin
    load_fmt = 32'h0;
    case (req_q.op)
      OP_LB:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: load_fmt = {24'h0, byte_sel};
      OP_LH:  load_fmt = {{16{half_sel[15]}}, half_sel};
      OP_LHU: load_fmt = {16'h0, half_sel};
      OP_LW:  load_fmt = bus.readdata;
      OP_LWL: load_fmt = (bus.readdata << lsh) | (req_q.rt & ~(32'hFFFF_FFFF << lsh));
      OP_LWR: load_fmt = rd_shr | (req_q.rt & ~(32'hFFFF_FFFF >> rsh));
      default: load_fmt = 32'h0;
    endcase
  end

  always_comb begin
    state_d  = state;
    accept   = (state == IDLE) && bus.req_valid;
    bus_done = (state == BUS) && !bus.waitrequest;
    timeout  = TO_EN && (state == BUS) && bus.waitrequest && (wait_cnt == T_LAST);
    case (state)
      IDLE: if (accept) state_d = reject ? RESP : BUS;
      BUS:  if (bus_done || timeout) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      req_q    <= '0;
      wait_cnt <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      rvld_q   <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvld_q <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          req_q    <= '{op: bus.req_op, b: b_in, rt: bus.req_rt_data};
          wait_cnt <= '0;
          if (reject) begin
            rvld_q  <= 1'b1;
            rerr_q  <= 1'b1;
            rdata_q <= '0;
          end else begin
            addr_q  <= {eff[ADDR_WIDTH-1:2], 2'b00};
            wdata_q <= wd_in;
            be_q    <= be_in;
            read_q  <= ~bus.req_op[3];
            write_q <= bus.req_op[3];
          end
        end
        BUS: begin
          if (bus_done) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            rvld_q  <= 1'b1;
            rerr_q  <= 1'b0;
            rdata_q <= req_q.op[3] ? 32'h0 : load_fmt;
          end else if (timeout) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            rvld_q  <= 1'b1;
            rerr_q  <= 1'b1;
            rdata_q <= '0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: begin
          rerr_q  <= 1'b0;
          rdata_q <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = rvld_q;
  assign bus.resp_data  = rdata_q;
  assign bus.resp_err   = rerr_q;
  assign bus.address    = addr_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.writedata  = wdata_q;
  assign bus.byteenable = be_q;
endmodule

// File: tb/tb_mips_cpu_lsu.sv
// Directed bench for mips_cpu_lsu with TIMEOUT_CYCLES=4; cycle n is the clock period after the accepting edge 0.
module tb_mips_cpu_lsu;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_cpu_lsu_if #(.ADDR_WIDTH(32)) bus ();
  mips_cpu_lsu #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks   = 0;
  int failures = 0;

  int          r_strobes, r_first, r_resp_cyc;
  logic        r_stable, r_err;
  logic [31:0] r_data, r_addr, r_wd;
  logic [3:0]  r_be;

  // Issue one request, hold waitrequest high for the first `waits` bus cycles, record what the bus and response show.
  task automatic run_op(input logic [3:0] op, input logic [31:0] base, input logic [15:0] off,
                        input logic [31:0] rt, input int waits, input logic [31:0] rd);
    r_strobes = 0; r_first = 0; r_resp_cyc = 0; r_stable = 1'b1;
    r_err = 1'b0; r_data = 32'h0; r_addr = 32'h0; r_wd = 32'h0; r_be = 4'h0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_base = base; bus.req_offset = off;
    bus.req_rt_data = rt; bus.readdata = rd; bus.waitrequest = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 40 && r_resp_cyc == 0; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = 1'b0;
      bus.waitrequest = (c <= waits);
      if (bus.read || bus.write) begin
        if (r_strobes == 0) begin
          r_addr = bus.address; r_wd = bus.writedata; r_be = bus.byteenable; r_first = c;
        end else if (bus.address !== r_addr || bus.writedata !== r_wd || bus.byteenable !== r_be) begin
          r_stable = 1'b0;
        end
        r_strobes++;
      end
      if (bus.resp_valid) begin
        r_resp_cyc = c; r_data = bus.resp_data; r_err = bus.resp_err;
      end
    end
    bus.waitrequest = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.req_valid = 1'b1; bus.req_op = 4'd4; bus.req_base = 32'h1000; bus.req_offset = 16'h0;
    bus.req_rt_data = 32'h0; bus.waitrequest = 1'b0; bus.readdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
    checks++; if (bus.read !== 1'b0 || bus.write !== 1'b0) begin failures++; $display("FAIL reset_strobes got r=%b w=%b want 0", bus.read, bus.write); end
    checks++; if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 || bus.resp_data !== 32'h0) begin
      failures++; $display("FAIL reset_resp got v=%b e=%b d=%h want 0", bus.resp_valid, bus.resp_err, bus.resp_data); end
    checks++; if (bus.address !== 32'h0 || bus.writedata !== 32'h0 || bus.byteenable !== 4'h0) begin
      failures++; $display("FAIL reset_bus got a=%h wd=%h be=%b want 0", bus.address, bus.writedata, bus.byteenable); end
    bus.req_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_lw();
    run_op(4'd4, 32'h0000_1000, 16'h0004, 32'h0, 0, 32'hDEAD_BEEF);
    checks++; if (r_addr !== 32'h1004) begin failures++; $display("FAIL lw_addr got %h want 00001004", r_addr); end
    checks++; if (r_strobes !== 1 || r_first !== 1) begin failures++; $display("FAIL lw_read got %0d cycles from %0d want 1 from 1", r_strobes, r_first); end
    checks++; if (r_resp_cyc !== 2) begin failures++; $display("FAIL lw_resp_cycle got %0d want 2", r_resp_cyc); end
    checks++; if (r_data !== 32'hDEAD_BEEF || r_err !== 1'b0) begin failures++; $display("FAIL lw_data got %h err %b want deadbeef err 0", r_data, r_err); end
    checks++; if (r_be !== 4'b1111) begin failures++; $display("FAIL lw_be got %b want 1111", r_be); end
  endtask

  task automatic test_byte_half();
    run_op(4'd0, 32'h0000_1003, 16'h0000, 32'h0, 0, 32'h80FF_FFFF);
    checks++; if (r_data !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_data got %h want ffffff80", r_data); end
    run_op(4'd1, 32'h0000_1003, 16'h0000, 32'h0, 0, 32'h80FF_FFFF);
    checks++; if (r_data !== 32'h0000_0080) begin failures++; $display("FAIL lbu_data got %h want 00000080", r_data); end
    run_op(4'd0, 32'h0000_1007, 16'hFFFC, 32'h0, 0, 32'h80FF_FFFF);
    checks++; if (r_addr !== 32'h1000 || r_data !== 32'hFFFF_FF80) begin
      failures++; $display("FAIL lb_negoff got a=%h d=%h want 00001000 ffffff80", r_addr, r_data); end
    run_op(4'd2, 32'h0000_1002, 16'h0000, 32'h0, 0, 32'h8001_1234);
    checks++; if (r_data !== 32'hFFFF_8001) begin failures++; $display("FAIL lh_data got %h want ffff8001", r_data); end
    run_op(4'd3, 32'h0000_1002, 16'h0000, 32'h0, 0, 32'h8001_1234);
    checks++; if (r_data !== 32'h0000_8001) begin failures++; $display("FAIL lhu_data got %h want 00008001", r_data); end
  endtask

  task automatic test_store();
    run_op(4'd9, 32'h0000_2002, 16'h0000, 32'h1234_ABCD, 3, 32'h0);
    checks++; if (r_wd !== 32'hABCD_ABCD || r_be !== 4'b1100) begin failures++; $display("FAIL sh_lanes got wd=%h be=%b want abcdabcd 1100", r_wd, r_be); end
    checks++; if (r_strobes !== 4 || r_stable !== 1'b1) begin failures++; $display("FAIL sh_write got %0d cycles stable=%b want 4 stable=1", r_strobes, r_stable); end
    checks++; if (r_resp_cyc !== 5 || r_data !== 32'h0 || r_err !== 1'b0) begin
      failures++; $display("FAIL sh_resp got cyc=%0d d=%h e=%b want 5 0 0", r_resp_cyc, r_data, r_err); end
    run_op(4'd8, 32'h0000_4001, 16'h0000, 32'h0000_00A5, 0, 32'h0);
    checks++; if (r_wd !== 32'hA5A5_A5A5 || r_be !== 4'b0010 || r_addr !== 32'h4000) begin
      failures++; $display("FAIL sb_lanes got wd=%h be=%b a=%h want a5a5a5a5 0010 00004000", r_wd, r_be, r_addr); end
    run_op(4'd10, 32'h0000_4000, 16'h0008, 32'hCAFE_F00D, 0, 32'h0);
    checks++; if (r_wd !== 32'hCAFE_F00D || r_be !== 4'b1111 || r_addr !== 32'h4008) begin
      failures++; $display("FAIL sw_lanes got wd=%h be=%b a=%h want cafef00d 1111 00004008", r_wd, r_be, r_addr); end
  endtask

  task automatic test_merge();
    run_op(4'd5, 32'h0000_3001, 16'h0000, 32'h1122_3344, 0, 32'hAABB_CCDD);
    checks++; if (r_data !== 32'hCCDD_3344) begin failures++; $display("FAIL lwl_data got %h want ccdd3344", r_data); end
    run_op(4'd6, 32'h0000_3001, 16'h0000, 32'h1122_3344, 0, 32'hAABB_CCDD);
    checks++; if (r_data !== 32'h11AA_BBCC) begin failures++; $display("FAIL lwr_data got %h want 11aabbcc", r_data); end
  endtask

  task automatic test_timeout();
    run_op(4'd4, 32'h0000_5000, 16'h0000, 32'h0, 100, 32'h1234_5678);
    checks++; if (r_strobes !== 4) begin failures++; $display("FAIL to_read_cycles got %0d want 4", r_strobes); end
    checks++; if (r_resp_cyc !== 5 || r_err !== 1'b1 || r_data !== 32'h0) begin
      failures++; $display("FAIL to_resp got cyc=%0d e=%b d=%h want 5 1 0", r_resp_cyc, r_err, r_data); end
    run_op(4'd4, 32'h0000_5000, 16'h0000, 32'h0, 3, 32'h0102_0304);
    checks++; if (r_strobes !== 4 || r_resp_cyc !== 5) begin failures++; $display("FAIL to_edge_timing got %0d cycles resp %0d want 4 5", r_strobes, r_resp_cyc); end
    checks++; if (r_err !== 1'b0 || r_data !== 32'h0102_0304) begin failures++; $display("FAIL to_edge_resp got e=%b d=%h want 0 01020304", r_err, r_data); end
  endtask

  task automatic test_errors();
    run_op(4'd7, 32'h0000_1000, 16'h0000, 32'h0, 0, 32'hFFFF_FFFF);
    checks++; if (r_strobes !== 0 || r_resp_cyc !== 1 || r_err !== 1'b1 || r_data !== 32'h0) begin
      failures++; $display("FAIL illegal_op got strobes=%0d cyc=%0d e=%b d=%h want 0 1 1 0", r_strobes, r_resp_cyc, r_err, r_data); end
    run_op(4'd4, 32'h0000_1002, 16'h0000, 32'h0, 0, 32'h5566_7788);
`ifdef MIPS_LSU_ALIGN_CHECK_EN
    checks++; if (r_strobes !== 0 || r_resp_cyc !== 1 || r_err !== 1'b1 || r_data !== 32'h0) begin
      failures++; $display("FAIL misalign_lw got strobes=%0d cyc=%0d e=%b d=%h want 0 1 1 0", r_strobes, r_resp_cyc, r_err, r_data); end
`else
    checks++; if (r_addr !== 32'h1000 || r_resp_cyc !== 2 || r_err !== 1'b0 || r_data !== 32'h5566_7788) begin
      failures++; $display("FAIL unaligned_lw got a=%h cyc=%0d e=%b d=%h want 00001000 2 0 55667788", r_addr, r_resp_cyc, r_err, r_data); end
`endif
  endtask

  task automatic test_reset_mid_access();
    logic saw_resp;
    saw_resp = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 4'd4; bus.req_base = 32'h6000; bus.req_offset = 16'h0;
    bus.waitrequest = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++; if (bus.read !== 1'b1) begin failures++; $display("FAIL mid_rst_pre_read got %b want 1", bus.read); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.read !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      failures++; $display("FAIL mid_rst_abort got r=%b rdy=%b v=%b want 0 1 0", bus.read, bus.req_ready, bus.resp_valid); end
    reset = 1'b1;
    bus.waitrequest = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.resp_valid || bus.read) saw_resp = 1'b1;
    end
    checks++; if (saw_resp !== 1'b0) begin failures++; $display("FAIL mid_rst_no_resp got activity=%b want 0", saw_resp); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_byte_half();
    test_store();
    test_merge();
    test_timeout();
    test_errors();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
